inv_sbox_gen: RTL and testbench
===============================

Name: inv_sbox_gen

Overview:
- Decryption-side counterpart of the chaos S-box generator.
- Once the forward S-box is complete (start tied to the generator's done_sbox), it reads the forward table and builds the inverse table so that inv[sbox[i]] = i.
- It checks that the forward table is a bijection.
- It then serves inverse-substitution lookups for the decryption datapath over a valid/ready stream.

Parameters:
- DATA_W, 8, symbol width; the table has 2^DATA_W entries.
- DEPTH, 256, number of entries; must equal 2^DATA_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  build request, sampled level-high; driven from done_sbox.
- sbox_rd_en  output  1  forward S-box read strobe.
- sbox_rd_addr  output  DATA_W  forward S-box read address.
- sbox_rd_data  input  DATA_W  forward S-box data; valid exactly one cycle after sbox_rd_en.
- busy  output  1  build in progress.
- done_inv  output  1  inverse table valid and bijective.
- err_dup  output  1  sticky flag: duplicate value found in the forward S-box.
- lut_in_valid  input  1  lookup request valid.
- lut_in_ready  output  1  lookup request accepted.
- lut_in_data  input  DATA_W  ciphertext symbol to invert.
- lut_out_valid  output  1  result valid.
- lut_out_ready  input  1  downstream ready.
- lut_out_data  output  DATA_W  inv[lut_in_data].

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; address counter and write pipeline are cleared.
  - seen bitmap (DEPTH bits) is cleared.
  - All outputs are 0.
  - Inverse table contents are don't-care.
- FSM states: IDLE, BUILD, DRAIN, DONE, ERR.
- IDLE, DONE, ERR with start=1:
  - Move to BUILD.
  - Clear seen, err_dup and done_inv on that edge.
  - Clear the address counter to 0.
- start is ignored in BUILD and DRAIN; no restart and no abort.
- BUILD:
  - sbox_rd_en=1 and sbox_rd_addr=counter, with the counter running 0..DEPTH-1, one address per cycle.
  - After the read at DEPTH-1 is issued, move to DRAIN.
  - busy=1 in BUILD and DRAIN.
- Write stage, one cycle after each read:
  - addr_d1 is the address registered from the previous cycle.
  - Write inv[sbox_rd_data] = addr_d1 and set seen[sbox_rd_data].
  - If seen[sbox_rd_data] was already 1, set err_dup.
  - On a duplicate, the write still occurs (last writer wins).
- DRAIN: performs the final write, then moves to DONE if err_dup=0 (including a duplicate detected in this same cycle), otherwise to ERR.
- Latency: with start sampled at edge E0, done_inv rises at edge E0+DEPTH+2 (258 for the defaults).
- DONE: done_inv=1.
- ERR: done_inv=0, err_dup=1; stays until a new start or reset.
- Lookup pipeline (1 stage, registered):
  - lut_in_ready = done_inv & (!lut_out_valid | lut_out_ready).
  - On in-handshake: lut_out_data <= inv[lut_in_data] and lut_out_valid <= 1.
  - On out-handshake with no new input: lut_out_valid <= 0.
  - Simultaneous in and out handshakes sustain 1 result/cycle.
  - lut_out_data is held stable while lut_out_valid=1 and lut_out_ready=0.
- Rebuild while a result is pending:
  - lut_out_valid and lut_out_data are held until consumed.
  - No new lookups are accepted until done_inv returns.
- Reset mid-build: aborts immediately to IDLE with all outputs 0.
  - A later start rebuilds from address 0.
- Width rule: DATA_W-bit addresses and data, unsigned; the counter terminal value is DEPTH-1, with no wrap beyond it.

Test Plan:
- Identity S-box (sbox[i]=i), start pulse:
  - Required: done_inv rises 258 cycles after start and err_dup=0.
  - Lookups 0x00, 0x7F, 0xFF return 0x00, 0x7F, 0xFF.
- Reversal S-box (sbox[i]=0xFF-i):
  - Lookup 0x00 returns 0xFF; 0x01 returns 0xFE; 0xA5 returns 0x5A.
- Random permutation from a seeded LFSR, 256 back-to-back lookups with lut_out_ready=1:
  - Required: one result per cycle, with inv[sbox[x]]==x for all x.
- Duplicate S-box (sbox[3]=sbox[200]=0x10):
  - Required: err_dup=1, the FSM ends in ERR, done_inv=0 and lut_in_ready stays 0.
  - A re-start with a valid table clears err_dup and reaches DONE.
- Backpressure, lut_out_ready low for 5 cycles with a pending result:
  - Required: lut_out_data is held and lut_in_ready=0.
  - On release, results are delivered in order with no loss or duplication.
- rst pulsed low at build cycle 100:
  - Required: busy=0 and sbox_rd_en=0 immediately.
  - A later start produces a full 258-cycle rebuild.
  - A start asserted mid-BUILD has no effect.

Source files
------------

// File: rtl/inv_sbox_gen.sv
// ----------------------------------------------------------------------------
// inv_sbox_gen
//   Decryption-side companion of the chaos S-box generator. On a start request
//   it reads the forward S-box once, address 0..DEPTH-1, one entry per cycle.
//   From that table it builds the inverse table (inv[sbox[i]] = i) and keeps a
//   bitmap of the values already seen, so that a non-bijective forward table
//   is flagged. After a clean build it serves inverse lookups through a
//   one-stage registered valid/ready pipeline.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   start          build request (level, sampled in IDLE/DONE/ERR only)
//   sbox_rd_en     forward S-box read strobe
//   sbox_rd_addr   forward S-box read address
//   sbox_rd_data   forward S-box read data, one cycle after sbox_rd_en
//   busy           build in progress (BUILD or DRAIN)
//   done_inv       inverse table valid and bijective
//   err_dup        sticky: a duplicate value was found in the forward table
//   lut_in_*       lookup request stream (symbol to invert)
//   lut_out_*      lookup result stream (inv[symbol])
// ----------------------------------------------------------------------------
module inv_sbox_gen #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              sbox_rd_en,
   output logic [DATA_W-1:0] sbox_rd_addr,
   input  logic [DATA_W-1:0] sbox_rd_data,
   output logic              busy,
   output logic              done_inv,
   output logic              err_dup,
   input  logic              lut_in_valid,
   output logic              lut_in_ready,
   input  logic [DATA_W-1:0] lut_in_data,
   output logic              lut_out_valid,
   input  logic              lut_out_ready,
   output logic [DATA_W-1:0] lut_out_data
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BUILD = 3'd1,
      DRAIN = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam logic [DATA_W-1:0] LAST_ADDR = DATA_W'(DEPTH - 1);

   state_t              state_r;
   state_t              state_s;
   logic                launch_s;
   logic                dup_s;
   logic [DATA_W-1:0]   cnt_r;
   logic                rd_en_r;
   logic                busy_r;
   logic                done_r;
   logic                err_r;
   logic                wr_en_r;
   logic [DATA_W-1:0]   addr_d1_r;
   logic [DEPTH-1:0]    seen_r;
   logic [DATA_W-1:0]   inv_mem [DEPTH];
   logic                in_ready_s;
   logic                in_hs_s;
   logic                out_valid_r;
   logic [DATA_W-1:0]   out_data_r;

   // Write stage hits a value already marked in the bitmap -> duplicate.
   assign dup_s    = wr_en_r & seen_r[sbox_rd_data];
   assign launch_s = start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERR));

   // Next-state logic of the build controller.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_s = BUILD;
            end else begin
               state_s = state_r;
            end
         end
         BUILD: begin
            if (cnt_r == LAST_ADDR) begin
               state_s = DRAIN;
            end else begin
               state_s = BUILD;
            end
         end
         DRAIN: begin
            // The final write may itself reveal a duplicate, so dup_s is
            // considered alongside the sticky flag.
            if (err_r | dup_s) begin
               state_s = ERR;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Controller state, read address counter, status outputs and write pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         cnt_r     <= {DATA_W{1'b0}};
         rd_en_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         wr_en_r   <= 1'b0;
         addr_d1_r <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_s;
         if (launch_s) begin
            cnt_r <= {DATA_W{1'b0}};
         end else if ((state_r == BUILD) && (cnt_r != LAST_ADDR)) begin
            cnt_r <= cnt_r + DATA_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         rd_en_r <= (state_s == BUILD);
         busy_r  <= (state_s == BUILD) || (state_s == DRAIN);
         // done follows DONE by one cycle so the last table write has landed.
         done_r  <= (state_r == DONE) && !launch_s;
         if (launch_s) begin
            err_r <= 1'b0;
         end else if (dup_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
         // The address presented this cycle pairs with the data returned next cycle.
         wr_en_r   <= rd_en_r;
         addr_d1_r <= cnt_r;
      end
   end

   // Bitmap of forward-table values already written.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seen_r <= {DEPTH{1'b0}};
      end else if (launch_s) begin
         seen_r <= {DEPTH{1'b0}};
      end else if (wr_en_r) begin
         seen_r[sbox_rd_data] <= 1'b1;
      end else begin
         seen_r <= seen_r;
      end
   end

   // Inverse table storage; a duplicate still overwrites (last writer wins).
   always_ff @(posedge clk) begin
      if (wr_en_r) begin
         inv_mem[sbox_rd_data] <= addr_d1_r;
      end
   end

   assign in_ready_s = done_r & (~out_valid_r | lut_out_ready);
   assign in_hs_s    = lut_in_valid & in_ready_s;

   // One-stage lookup pipeline; result held while downstream stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
      end else if (in_hs_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= inv_mem[lut_in_data];
      end else if (lut_out_ready) begin
         out_valid_r <= 1'b0;
         out_data_r  <= out_data_r;
      end else begin
         out_valid_r <= out_valid_r;
         out_data_r  <= out_data_r;
      end
   end

   assign sbox_rd_en    = rd_en_r;
   assign sbox_rd_addr  = cnt_r;
   assign busy          = busy_r;
   assign done_inv      = done_r;
   assign err_dup       = err_r;
   assign lut_in_ready  = in_ready_s;
   assign lut_out_valid = out_valid_r;
   assign lut_out_data  = out_data_r;

endmodule

// File: tb/tb_inv_sbox_gen.sv
// ----------------------------------------------------------------------------
// tb_inv_sbox_gen
//   Directed self-checking bench for inv_sbox_gen. A behavioural forward S-box
//   (registered read, one-cycle latency) feeds the DUT; expected inverse
//   values are hand-computed or derived from the table the bench loads.
// ----------------------------------------------------------------------------
module tb_inv_sbox_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic       sbox_rd_en;
   logic [7:0] sbox_rd_addr;
   logic [7:0] sbox_rd_data;
   logic       busy;
   logic       done_inv;
   logic       err_dup;
   logic       lut_in_valid;
   logic       lut_in_ready;
   logic [7:0] lut_in_data;
   logic       lut_out_valid;
   logic       lut_out_ready;
   logic [7:0] lut_out_data;

   logic [7:0] sbox_mem [256];
   logic [7:0] perm [256];
   int         n_checks;
   int         n_fail;
   int         lat;

   inv_sbox_gen #(.DATA_W(8), .DEPTH(256)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .sbox_rd_en   (sbox_rd_en),
      .sbox_rd_addr (sbox_rd_addr),
      .sbox_rd_data (sbox_rd_data),
      .busy         (busy),
      .done_inv     (done_inv),
      .err_dup      (err_dup),
      .lut_in_valid (lut_in_valid),
      .lut_in_ready (lut_in_ready),
      .lut_in_data  (lut_in_data),
      .lut_out_valid(lut_out_valid),
      .lut_out_ready(lut_out_ready),
      .lut_out_data (lut_out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Forward S-box model: data valid one cycle after the read strobe.
   always @(posedge clk) begin
      if (sbox_rd_en) sbox_rd_data <= sbox_mem[sbox_rd_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start, optionally re-pulse it mid-build, return cycles to done_inv.
   task automatic run_build(input int mid_start, output int cycles);
      start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 0;
      while (!done_inv && cycles < 300) begin
         start = (cycles == mid_start) ? 1'b1 : 1'b0;
         tick();
         cycles++;
      end
      start = 1'b0;
   endtask

   // Single lookup with downstream always ready.
   task automatic lookup(input string tag, input logic [7:0] sym, input logic [7:0] exp);
      lut_out_ready = 1'b1;
      lut_in_valid  = 1'b1;
      lut_in_data   = sym;
      #1;
      check_eq({tag, "_ready"}, 32'(lut_in_ready), 32'd1);
      tick();
      lut_in_valid = 1'b0;
      check_eq({tag, "_valid"}, 32'(lut_out_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(lut_out_data), 32'(exp));
      tick();
   endtask

   initial begin
      logic [31:0] rng;
      int          j;
      logic [7:0]  tmp;
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b0;
      start         = 1'b0;
      lut_in_valid  = 1'b0;
      lut_in_data   = 8'h00;
      lut_out_ready = 1'b1;
      for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i);
      repeat (3) tick();

      // Reset state
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done_inv), 32'd0);
      check_eq("rst_err", 32'(err_dup), 32'd0);
      check_eq("rst_rd_en", 32'(sbox_rd_en), 32'd0);
      check_eq("rst_out_valid", 32'(lut_out_valid), 32'd0);
      check_eq("rst_in_ready", 32'(lut_in_ready), 32'd0);
      rst = 1'b1;
      tick();
      check_eq("idle_in_ready", 32'(lut_in_ready), 32'd0);

      // Identity S-box
      run_build(-1, lat);
      check_eq("id_latency", 32'(lat), 32'd258);
      check_eq("id_err", 32'(err_dup), 32'd0);
      check_eq("id_busy_after", 32'(busy), 32'd0);
      lookup("id_00", 8'h00, 8'h00);
      lookup("id_7f", 8'h7F, 8'h7F);
      lookup("id_ff", 8'hFF, 8'hFF);

      // Reversal S-box, restarted from DONE
      for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(255 - i);
      run_build(-1, lat);
      check_eq("rev_latency", 32'(lat), 32'd258);
      lookup("rev_00", 8'h00, 8'hFF);
      lookup("rev_01", 8'h01, 8'hFE);
      lookup("rev_a5", 8'hA5, 8'h5A);

      // Random permutation (xorshift-driven shuffle), back-to-back lookups
      rng = 32'h1234_5678;
      for (int i = 0; i < 256; i++) perm[i] = 8'(i);
      for (int i = 255; i > 0; i--) begin
         rng = rng ^ (rng << 13);
         rng = rng ^ (rng >> 17);
         rng = rng ^ (rng << 5);
         j = int'(rng % 32'(i + 1));
         tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int i = 0; i < 256; i++) sbox_mem[i] = perm[i];
      run_build(-1, lat);
      check_eq("perm_latency", 32'(lat), 32'd258);
      check_eq("perm_err", 32'(err_dup), 32'd0);
      lut_out_ready = 1'b1;
      for (int x = 0; x < 256; x++) begin
         lut_in_valid = 1'b1;
         lut_in_data  = perm[x];
         #1;
         check_eq("perm_ready", 32'(lut_in_ready), 32'd1);
         tick();
         check_eq("perm_valid", 32'(lut_out_valid), 32'd1);
         check_eq("perm_data", 32'(lut_out_data), 32'(x));
      end
      lut_in_valid = 1'b0;
      tick();
      check_eq("perm_drained", 32'(lut_out_valid), 32'd0);

      // Duplicate S-box: 0x10 at index 3, 16 and 200
      for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i);
      sbox_mem[3]   = 8'h10;
      sbox_mem[200] = 8'h10;
      run_build(-1, lat);
      check_eq("dup_err", 32'(err_dup), 32'd1);
      check_eq("dup_done", 32'(done_inv), 32'd0);
      check_eq("dup_busy", 32'(busy), 32'd0);
      lut_in_valid = 1'b1;
      lut_in_data  = 8'h05;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("dup_in_ready", 32'(lut_in_ready), 32'd0);
         tick();
         check_eq("dup_out_valid", 32'(lut_out_valid), 32'd0);
      end
      lut_in_valid = 1'b0;

      // Recover with a valid (reversal) table
      for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(255 - i);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("recover_err_clr", 32'(err_dup), 32'd0);
      check_eq("recover_busy", 32'(busy), 32'd1);
      lat = 0;
      while (!done_inv && lat < 300) begin
         tick();
         lat++;
      end
      check_eq("recover_latency", 32'(lat), 32'd258);
      check_eq("recover_err", 32'(err_dup), 32'd0);

      // Backpressure: one result pending for 5 cycles
      lut_out_ready = 1'b0;
      lut_in_valid  = 1'b1;
      lut_in_data   = 8'h11;
      tick();
      lut_in_data = 8'h22;
      for (int k = 0; k < 5; k++) begin
         check_eq("bp_valid", 32'(lut_out_valid), 32'd1);
         check_eq("bp_hold", 32'(lut_out_data), 32'h0EE);
         check_eq("bp_in_ready", 32'(lut_in_ready), 32'd0);
         tick();
      end
      lut_out_ready = 1'b1;
      #1;
      check_eq("bp_release_ready", 32'(lut_in_ready), 32'd1);
      check_eq("bp_first", 32'(lut_out_data), 32'h0EE);
      tick();
      lut_in_data = 8'h33;
      check_eq("bp_second_valid", 32'(lut_out_valid), 32'd1);
      check_eq("bp_second", 32'(lut_out_data), 32'h0DD);
      tick();
      lut_in_valid = 1'b0;
      check_eq("bp_third_valid", 32'(lut_out_valid), 32'd1);
      check_eq("bp_third", 32'(lut_out_data), 32'h0CC);
      tick();
      check_eq("bp_empty", 32'(lut_out_valid), 32'd0);

      // Reset at build cycle 100, then a rebuild with a stray mid-build start
      for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (100) tick();
      check_eq("mid_busy_before", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_rd_en", 32'(sbox_rd_en), 32'd0);
      check_eq("mid_rst_done", 32'(done_inv), 32'd0);
      check_eq("mid_rst_addr", 32'(sbox_rd_addr), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      check_eq("mid_idle_busy", 32'(busy), 32'd0);
      run_build(50, lat);
      check_eq("mid_rebuild_latency", 32'(lat), 32'd258);
      check_eq("mid_rebuild_err", 32'(err_dup), 32'd0);
      lookup("mid_5a", 8'h5A, 8'h5A);
      lookup("mid_c3", 8'hC3, 8'hC3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
